// File: rtl/traffic_light_nph.sv
// traffic_light_nph: N-phase traffic light controller.
//
// Phase 0 is the main road: it rests in green and is always recalled while
// another phase is being served. Side phases 1..NPH-1 are served on demand.
// Their demand is latched into sticky pending bits. Green lasts at least
// GREEN_CYC cycles and is left only when another phase is waiting. Yellow
// lasts YEL_CYC cycles. The next phase is picked round-robin from p+1.
//
// Build option: define TLC_ALLRED_EN to insert an ALLRED_CYC-cycle all-red
// clearance between yellow and the next green. Without it, yellow goes
// straight to the next green and st never reads 2.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req    in   [NPH] per-phase demand sensor (req[0] ignored)
//   grn    out  [NPH] green lamps (registered)
//   yel    out  [NPH] yellow lamps (registered)
//   red    out  [NPH] red lamps (registered)
//   phase  out  [3]   phase owning green/yellow
//   st     out  [2]   0 GREEN, 1 YELLOW, 2 ALLRED
module traffic_light_nph #(
  parameter int unsigned NPH        = 3,
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YEL_CYC    = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned TW         = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NPH-1:0] req,
  output logic [NPH-1:0] grn,
  output logic [NPH-1:0] yel,
  output logic [NPH-1:0] red,
  output logic [2:0]     phase,
  output logic [1:0]     st
);

  // Elaboration-time legality checks on the configuration.
  if (NPH < 2 || NPH > 8) begin : g_chk_nph
    $error("traffic_light_nph: NPH must be in 2..8");
  end
  if (GREEN_CYC < 2 || YEL_CYC < 1 || ALLRED_CYC < 1) begin : g_chk_cyc
    $error("traffic_light_nph: cycle counts out of range");
  end
  if (TW < 32 && (64'(GREEN_CYC) > (64'd1 << TW) || 64'(YEL_CYC) > (64'd1 << TW) ||
                  64'(ALLRED_CYC) > (64'd1 << TW))) begin : g_chk_tw
    $error("traffic_light_nph: TW too narrow for cycle counts");
  end

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StAllRed = 2'd2
  } state_e;

  localparam logic [TW-1:0] GreenLast = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] YelLast   = TW'(YEL_CYC - 1);
`ifdef TLC_ALLRED_EN
  localparam logic [TW-1:0] AllRedLast = TW'(ALLRED_CYC - 1);
`endif

  state_e         st_q, st_d;
  logic [2:0]     phase_q, phase_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [NPH-1:0] pend_q, pend_d;
  logic [NPH-1:0] grn_q, grn_d;
  logic [NPH-1:0] yel_q, yel_d;
  logic [NPH-1:0] red_q, red_d;

  // Phase 0 has no sensor; its demand comes only from the recall rule.
  logic unused_req0;
  assign unused_req0 = req[0];

  // ---------------------------------------------------------------------------
  // Round-robin search for the next phase, starting at phase_q+1. The search
  // never needs to wrap back onto phase_q: when phase_q != 0 the recall of
  // phase 0 is always found first, and when phase_q == 0 nothing can be
  // pending on phase 0 itself.
  // ---------------------------------------------------------------------------
  logic [7:0] pend_ext;
  logic [2:0] idx;
  logic [2:0] next_phase;
  logic       next_found;

  always_comb begin
    pend_ext             = '0;
    pend_ext[NPH-1:0]    = pend_q;
    pend_ext[0]          = (phase_q != 3'd0);
    idx                  = '0;
    next_phase           = phase_q;
    next_found           = 1'b0;
    for (int unsigned k = 1; k < NPH; k++) begin
      idx = 3'((32'(phase_q) + k) % NPH);
      if (!next_found && pend_ext[idx]) begin
        next_found = 1'b1;
        next_phase = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  logic enter_green;

  always_comb begin
    st_d        = st_q;
    phase_d     = phase_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    enter_green = 1'b0;

    // Latch demand, except from the phase currently showing green.
    for (int unsigned i = 1; i < NPH; i++) begin
      if (req[i] && !(st_q == StGreen && phase_q == 3'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;

    unique case (st_q)
      StGreen: begin
        if (timer_q == GreenLast) begin
          // Minimum green served; leave only if someone else is waiting.
          if (next_found) begin
            st_d    = StYellow;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StYellow: begin
        if (timer_q == YelLast) begin
          timer_d = '0;
`ifdef TLC_ALLRED_EN
          st_d    = StAllRed;
`else
          st_d        = StGreen;
          phase_d     = next_phase;
          enter_green = 1'b1;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef TLC_ALLRED_EN
      StAllRed: begin
        if (timer_q == AllRedLast) begin
          timer_d     = '0;
          st_d        = StGreen;
          phase_d     = next_phase;
          enter_green = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      default: begin
        // Unreachable encoding: recover to the resting state.
        st_d    = StGreen;
        phase_d = '0;
        timer_d = '0;
      end
    endcase

    // Serving a phase consumes its demand, overriding a same-cycle request.
    for (int unsigned i = 0; i < NPH; i++) begin
      if (enter_green && phase_d == 3'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Lamp decode from the next state so the lamps are registered with it.
  always_comb begin
    grn_d = '0;
    yel_d = '0;
    for (int unsigned i = 0; i < NPH; i++) begin
      if (phase_d == 3'(i)) begin
        grn_d[i] = (st_d == StGreen);
        yel_d[i] = (st_d == StYellow);
      end
    end
    red_d = ~(grn_d | yel_d);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StGreen;
      phase_q <= '0;
      timer_q <= '0;
      pend_q  <= '0;
      grn_q   <= NPH'(1);
      yel_q   <= '0;
      red_q   <= ~NPH'(1);
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      grn_q   <= grn_d;
      yel_q   <= yel_d;
      red_q   <= red_d;
    end
  end

  assign grn   = grn_q;
  assign yel   = yel_q;
  assign red   = red_q;
  assign phase = phase_q;
  assign st    = st_q;

endmodule

// File: tb/tb_traffic_light_nph.sv
// Self-checking bench for traffic_light_nph: directed scenarios plus random
// demand and resets, compared every cycle against a behavioural model.
module tb_traffic_light_nph;

  localparam int unsigned NPH        = 3;
  localparam int unsigned GREEN_CYC  = 8;
  localparam int unsigned YEL_CYC    = 3;
  localparam int unsigned ALLRED_CYC = 2;
  localparam int unsigned TW         = 8;
`ifdef TLC_ALLRED_EN
  localparam bit AllRedEn = 1'b1;
`else
  localparam bit AllRedEn = 1'b0;
`endif
  // Cycles one phase occupies from green entry to the next green entry.
  localparam int PerPhase = GREEN_CYC + YEL_CYC + (AllRedEn ? ALLRED_CYC : 0);

  logic           clk = 1'b0;
  logic           rst;
  logic [NPH-1:0] req;
  logic [NPH-1:0] grn, yel, red;
  logic [2:0]     phase;
  logic [1:0]     st;

  always #5 clk = ~clk;

  traffic_light_nph #(
    .NPH       (NPH),
    .GREEN_CYC (GREEN_CYC),
    .YEL_CYC   (YEL_CYC),
    .ALLRED_CYC(ALLRED_CYC),
    .TW        (TW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grn  (grn),
    .yel  (yel),
    .red  (red),
    .phase(phase),
    .st   (st)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: mode 0 green, 1 yellow, 2 all-red; age = cycles spent in mode.
  int             m_mode, m_age, m_phase;
  logic [NPH-1:0] m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic bit bit_of(input logic [NPH-1:0] v, input int j);
    logic [NPH-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  // Waiting = latched demand, plus phase 0 whenever it is not the owner.
  function automatic bit waiting(input int j);
    if (j == 0) return (m_phase != 0);
    return bit_of(m_pend, j);
  endfunction

  function automatic int pick_next();
    for (int k = 1; k < NPH; k++) begin
      int j;
      j = (m_phase + k) % NPH;
      if (waiting(j)) return j;
    end
    return m_phase;
  endfunction

  task automatic model_step(input logic r, input logic [NPH-1:0] rq);
    logic [NPH-1:0] np;
    int             nx;
    bit             go_green;
    if (r) begin
      m_mode = 0; m_age = 0; m_phase = 0; m_pend = '0;
      return;
    end
    np = m_pend;
    for (int i = 1; i < NPH; i++)
      if (bit_of(rq, i) && !(m_mode == 0 && m_phase == i)) np = np | (NPH'(1) << i);
    nx       = pick_next();
    go_green = 1'b0;
    case (m_mode)
      0: begin
        if (m_age >= GREEN_CYC - 1 && nx != m_phase) begin
          m_mode = 1; m_age = 0;
        end else m_age++;
      end
      1: begin
        if (m_age == YEL_CYC - 1) begin
          if (AllRedEn) begin m_mode = 2; m_age = 0; end
          else go_green = 1'b1;
        end else m_age++;
      end
      default: begin
        if (m_age == ALLRED_CYC - 1) go_green = 1'b1;
        else m_age++;
      end
    endcase
    if (go_green) begin
      m_mode = 0; m_age = 0; m_phase = nx;
      np = np & ~(NPH'(1) << nx);
    end
    m_pend = np;
  endtask

  task automatic compare_outputs();
    logic [NPH-1:0] eg, ey, er, bad;
    eg  = (m_mode == 0) ? (NPH'(1) << m_phase) : '0;
    ey  = (m_mode == 1) ? (NPH'(1) << m_phase) : '0;
    er  = ~(eg | ey);
    bad = (grn & yel) | (grn & red) | (yel & red) | ~(grn | yel | red);
    check("grn", 32'(grn), 32'(eg));
    check("yel", 32'(yel), 32'(ey));
    check("red", 32'(red), 32'(er));
    check("st", 32'(st), 32'(m_mode));
    check("phase", 32'(phase), 32'(m_phase));
    check("lamp_exclusive", 32'(bad), 32'd0);
  endtask

  // One clock: advance the model with the inputs now driven, then check.
  task automatic tick();
    model_step(rst, req);
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else cyc++;
    compare_outputs();
  endtask

  // Leaves the bench in cycle 0 with rst low.
  task automatic run_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      req = NPH'($urandom);
      tick();
    end
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    int t0, t1, t2, ty, served, bad_rest;
    rst = 1'b1;
    req = '0;

    // Side-phase request at cycle 2: full cycle and return to phase 0.
    run_reset(2);
    t2 = -1; t0 = -1; ty = -1;
    for (int n = 0; n < 40; n++) begin
      req = (cyc == 2) ? 3'b100 : 3'b000;
      tick();
      if (yel == 3'b001 && ty < 0) ty = cyc;
      if (grn == 3'b100 && t2 < 0) t2 = cyc;
      if (t2 >= 0 && grn == 3'b001 && t0 < 0) t0 = cyc;
    end
    check("yel0_start", 32'(ty), 32'(GREEN_CYC));
    check("grn2_start", 32'(t2), 32'(PerPhase));
    check("grn0_return", 32'(t0), 32'(2 * PerPhase));

    // Two requests at cycle 1: served in round-robin order.
    run_reset(1);
    t1 = -1; t2 = -1; t0 = -1;
    for (int n = 0; n < 50; n++) begin
      req = (cyc == 1) ? 3'b110 : 3'b000;
      tick();
      if (grn == 3'b010 && t1 < 0) t1 = cyc;
      if (grn == 3'b100 && t2 < 0) t2 = cyc;
      if (t2 >= 0 && grn == 3'b001 && t0 < 0) t0 = cyc;
    end
    check("rr_grn1", 32'(t1), 32'(PerPhase));
    check("rr_grn2", 32'(t2), 32'(2 * PerPhase));
    check("rr_grn0", 32'(t0), 32'(3 * PerPhase));

    // Reset mid-yellow discards the pending request.
    run_reset(1);
    served = 0;
    for (int n = 0; n < 70; n++) begin
      req = (n == 2) ? 3'b100 : 3'b000;
      rst = (n == 9);
      tick();
      if (n >= 9 && grn[2]) served++;
    end
    rst = 1'b0;
    check("reset_drops_pending", 32'(served), 32'd0);

    // No side demand, req[0] toggling: phase 0 rests in green.
    run_reset(1);
    bad_rest = 0;
    for (int n = 0; n < 100; n++) begin
      req = {2'b00, n[0]};
      tick();
      if (grn != 3'b001 || phase != 3'd0) bad_rest++;
    end
    check("phase0_rest", 32'(bad_rest), 32'd0);

    // Random demand with occasional resets.
    run_reset(3);
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NPH; i++) req[i] = ($urandom_range(0, 11) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
